// File: rtl/seq_step_ctrl.sv
// seq_step_ctrl: button/time-base controller for the rotating one-hot sequencer.
// Macro SEQ_BOUNCE_EN enables ping-pong auto stepping in RUN.
//
// Ports:
//   clk, nrst        clock, async active-low reset
//   strobe           time-base tick (one-cycle pulse)
//   btn_left/right   one-cycle presses: step (IDLE) or aim (RUN)
//   btn_play         toggle auto-run
//   btn_clear        re-home the sequencer
//   period           strobes per auto step (0 acts as 1)
//   go_left/right    one-cycle step commands
//   srst             one-cycle re-home command
//   running          high in RUN
//   dir              0 = left, 1 = right
//   pos              shadow index of the lit bit
module seq_step_ctrl #(
    parameter int WIDTH    = 8,
    parameter int PERIOD_W = 8
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     strobe,
    input  logic                     btn_left,
    input  logic                     btn_right,
    input  logic                     btn_play,
    input  logic                     btn_clear,
    input  logic [PERIOD_W-1:0]      period,
    output logic                     go_left,
    output logic                     go_right,
    output logic                     srst,
    output logic                     running,
    output logic                     dir,
    output logic [$clog2(WIDTH)-1:0] pos
);

    localparam int PW = $clog2(WIDTH);
    localparam logic [PW-1:0] PMAX = PW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        CLEAR
    } state_t;

    state_t              state;
    logic [PERIOD_W-1:0] cnt;
    logic [PERIOD_W-1:0] per_m1;
    logic                fire;
    logic                wrap_l;
    logic                wrap_r;
    logic [PW-1:0]       pos_inc;
    logic [PW-1:0]       pos_dec;
    logic                auto_dir;
    logic                one_l;
    logic                one_r;

    // A period of 0 behaves like 1: step on every strobe.
    assign per_m1 = (period == '0) ? '0 : period - 1'b1;
    // >= so that shrinking the period below cnt fires on the next strobe.
    assign fire   = (cnt >= per_m1);

    assign wrap_l  = (pos == PMAX);
    assign wrap_r  = (pos == '0);
    assign pos_inc = wrap_l ? '0 : pos + 1'b1;
    assign pos_dec = wrap_r ? PMAX : pos - 1'b1;

    // Simultaneous left+right presses cancel each other.
    assign one_l = btn_left & ~btn_right;
    assign one_r = btn_right & ~btn_left;

`ifdef SEQ_BOUNCE_EN
    // Reverse instead of wrapping when an auto step hits the ring end.
    assign auto_dir = (dir ? wrap_r : wrap_l) ? ~dir : dir;
`else
    assign auto_dir = dir;
`endif

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state    <= IDLE;
            cnt      <= '0;
            go_left  <= 1'b0;
            go_right <= 1'b0;
            srst     <= 1'b0;
            running  <= 1'b0;
            dir      <= 1'b0;
            pos      <= PMAX;
        end else begin
            go_left  <= 1'b0;
            go_right <= 1'b0;
            srst     <= 1'b0;
            if (btn_clear && state != CLEAR) begin
                state   <= CLEAR;
                srst    <= 1'b1;
                pos     <= PMAX;
                cnt     <= '0;
                running <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (btn_play) begin
                            state   <= RUN;
                            running <= 1'b1;
                            cnt     <= '0;
                        end else if (one_l) begin
                            go_left <= 1'b1;
                            pos     <= pos_inc;
                            dir     <= 1'b0;
                        end else if (one_r) begin
                            go_right <= 1'b1;
                            pos      <= pos_dec;
                            dir      <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (btn_play) begin
                            state   <= IDLE;
                            running <= 1'b0;
                            cnt     <= '0;
                        end else if (one_l) begin
                            dir <= 1'b0;
                        end else if (one_r) begin
                            dir <= 1'b1;
                        end else if (strobe) begin
                            if (fire) begin
                                cnt <= '0;
                                dir <= auto_dir;
                                if (auto_dir) begin
                                    go_right <= 1'b1;
                                    pos      <= pos_dec;
                                end else begin
                                    go_left <= 1'b1;
                                    pos     <= pos_inc;
                                end
                            end else if (cnt != '1) begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                    end
                    CLEAR: begin
                        // Presses in this cycle are dropped.
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
